// File: rtl/typing_timer_pkg.sv
// rtl/typing_timer_pkg.sv - shared state encodings and default limits for typing_timer
package typing_timer_pkg;

  // Controller states; encodings are fixed so the display/debug path can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_SAT  = 2'd3
  } state_e;

  // Largest value four BCD digits can show.
  localparam int DEFAULT_MAX_COUNT = 9999;

  // Misses counter width and its ceiling.
  localparam int MISS_W   = 4;
  localparam int MISS_MAX = 15;

endpackage

// File: rtl/typing_timer_tick_gen.sv
// rtl/typing_timer_tick_gen.sv - prescaler producing one tick per CLK_HZ/TICK_HZ cycles
module tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick on the last count of each period; nothing fires while disabled.
  assign tick = en && (cnt_q == CW'(DIV - 1));

  // Count up while enabled, wrap on tick, and clear whenever disabled so a
  // fresh enable always waits a full period before the first tick.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/typing_timer.sv
// rtl/typing_timer.sv - reaction timer: counts ticks plus wrong-key penalties until the target key
module typing_timer
  import typing_timer_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT,
  parameter int PENALTY   = 250,
  parameter int WIDTH     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              letter_valid,
  input  logic [3:0]        letter,
  input  logic [3:0]        target,
  output logic [WIDTH-1:0]  timerout,
  output logic              running,
  output logic              done,
  output logic              overflow,
  output logic [MISS_W-1:0] misses
);

  localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(MAX_COUNT);
  localparam logic [WIDTH:0] PEN_W = (WIDTH + 1)'(PENALTY);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    timerout_q, timerout_d;
  logic [MISS_W-1:0]   misses_q, misses_d;
  logic [3:0]          target_q, target_d;

  logic                tick;
  logic                tick_en;
  logic [WIDTH:0]      add;
  logic [WIDTH:0]      sum;
  logic                hit;
  logic                miss;

  // The prescaler only runs in RUN; holding it off during a restart cycle
  // clears it so the restarted run also waits a full period for its first tick.
  assign tick_en = (state_q == ST_RUN) && !start;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .tick (tick)
  );

  assign hit  = letter_valid && (letter == target_q);
  assign miss = letter_valid && (letter != target_q);

  // Amount to add this cycle and the widened sum used for the saturation test.
  always_comb begin
    add = '0;
    if (miss) begin
      add = PEN_W + (tick ? (WIDTH + 1)'(1) : '0);
    end else if (tick) begin
      add = (WIDTH + 1)'(1);
    end
    sum = {1'b0, timerout_q} + add;
  end

  // Next-state and accumulator logic; everything holds unless a rule below fires.
  always_comb begin
    state_d    = state_q;
    timerout_d = timerout_q;
    misses_d   = misses_q;
    target_d   = target_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_SAT: begin
        if (start) begin
          state_d    = ST_RUN;
          timerout_d = '0;
          misses_d   = '0;
          target_d   = target;
        end
      end
      ST_RUN: begin
        if (start) begin
          timerout_d = '0;
          misses_d   = '0;
          target_d   = target;
        end else if (hit) begin
          // Correct key freezes the count; a coincident tick is dropped.
          state_d = ST_DONE;
        end else begin
          if (miss && (misses_q != MISS_W'(MISS_MAX))) begin
            misses_d = misses_q + MISS_W'(1);
          end
          if (add != '0) begin
            if (sum >= MAX_W) begin
              timerout_d = MAX_W[WIDTH-1:0];
              state_d    = ST_SAT;
            end else begin
              timerout_d = sum[WIDTH-1:0];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any same-cycle start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timerout_q <= '0;
      misses_q   <= '0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      timerout_q <= timerout_d;
      misses_q   <= misses_d;
      target_q   <= target_d;
    end
  end

  assign timerout = timerout_q;
  assign misses   = misses_q;
  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign overflow = (state_q == ST_SAT);

endmodule

// File: tb/tb_typing_timer.sv
// tb/tb_typing_timer.sv - directed and randomized checks of typing_timer against a behavioural model
module tb_typing_timer;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MAXC    = 50;
  localparam int PEN     = 5;
  localparam int W       = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         letter_valid;
  logic [3:0]   letter;
  logic [3:0]   target;
  logic [W-1:0] timerout;
  logic         running;
  logic         done;
  logic         overflow;
  logic [3:0]   misses;

  int tests  = 0;
  int errors = 0;

  // Behavioural model: 0 idle, 1 timing, 2 finished, 3 saturated.
  int m_state;
  int m_t;
  int m_miss;
  int m_tgt;
  int run_edges;

  typing_timer #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .MAX_COUNT (MAXC),
    .PENALTY   (PEN),
    .WIDTH     (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .letter_valid (letter_valid),
    .letter       (letter),
    .target       (target),
    .timerout     (timerout),
    .running      (running),
    .done         (done),
    .overflow     (overflow),
    .misses       (misses)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_restart();
    m_state   = 1;
    m_t       = 0;
    m_miss    = 0;
    m_tgt     = int'(target);
    run_edges = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs as driven.
  task automatic model_edge();
    bit tick;
    int addv;
    if (rst) begin
      m_state = 0; m_t = 0; m_miss = 0; m_tgt = 0; run_edges = 0;
    end else if (m_state == 1) begin
      if (start) begin
        model_restart();
      end else begin
        run_edges++;
        tick = (run_edges % DIV) == 0;
        if (letter_valid && int'(letter) == m_tgt) begin
          m_state = 2;
        end else begin
          addv = (tick ? 1 : 0);
          if (letter_valid) begin
            addv += PEN;
            if (m_miss < 15) m_miss++;
          end
          if (addv > 0) begin
            if (m_t + addv >= MAXC) begin
              m_t = MAXC;
              m_state = 3;
            end else begin
              m_t += addv;
            end
          end
        end
      end
    end else if (start) begin
      model_restart();
    end
  endtask

  task automatic check_model();
    check("timerout", int'(timerout), m_t);
    check("misses",   int'(misses),   m_miss);
    check("running",  int'(running),  (m_state == 1) ? 1 : 0);
    check("done",     int'(done),     (m_state == 2) ? 1 : 0);
    check("overflow", int'(overflow), (m_state == 3) ? 1 : 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input bit r, input bit s, input bit lv, input logic [3:0] l);
    rst = r; start = s; letter_valid = lv; letter = l;
    cyc();
    rst = 1'b0; start = 1'b0; letter_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; letter_valid = 1'b0; letter = 4'h0; target = 4'h0;
    m_state = 0; m_t = 0; m_miss = 0; m_tgt = 0; run_edges = 0;

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    check("rst_timerout", int'(timerout), 0);
    check("rst_flags", int'({running, done, overflow}), 0);

    // Keys in IDLE are ignored
    drive(1'b0, 1'b0, 1'b1, 4'h3);
    check("idle_key", int'({running, done, misses}), 0);

    // 1: start with target 3, 35 quiet cycles
    target = 4'h3;
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    idle(35);
    check("t1_timerout", int'(timerout), 3);
    check("t1_running", int'(running), 1);

    // 2: correct key on a tick cycle freezes the count
    idle(4);
    drive(1'b0, 1'b0, 1'b1, 4'h3);
    check("t2_done", int'(done), 1);
    check("t2_timerout", int'(timerout), 3);
    idle(25);
    check("t2_frozen", int'(timerout), 3);
    drive(1'b0, 1'b0, 1'b1, 4'h1);
    check("t2_ignore_key", int'(misses), 0);

    // 5: restart from DONE with a new target; old target is now a miss
    target = 4'h7;
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    check("t5_timerout", int'(timerout), 0);
    check("t5_running", int'(running), 1);
    drive(1'b0, 1'b0, 1'b1, 4'h3);
    check("t5_miss", int'(misses), 1);
    check("t5_penalty", int'(timerout), PEN);

    // 3: restart, two wrong keys at count 2
    target = 4'h3;
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    idle(25);
    check("t3_pre", int'(timerout), 2);
    drive(1'b0, 1'b0, 1'b1, 4'h1);
    drive(1'b0, 1'b0, 1'b1, 4'h2);
    check("t3_timerout", int'(timerout), 12);
    check("t3_misses", int'(misses), 2);
    check("t3_running", int'(running), 1);

    // 4: climb to 48, then a wrong key saturates
    for (int i = 0; i < 600 && int'(timerout) < 48; i++) idle(1);
    check("t4_at48", int'(timerout), 48);
    drive(1'b0, 1'b0, 1'b1, 4'h9);
    check("t4_timerout", int'(timerout), MAXC);
    check("t4_overflow", int'(overflow), 1);
    check("t4_running", int'(running), 0);
    drive(1'b0, 1'b0, 1'b1, 4'h3);
    drive(1'b0, 1'b0, 1'b1, 4'h5);
    idle(15);
    check("t4_hold", int'(timerout), MAXC);
    check("t4_hold_misses", int'(misses), 3);

    // 6: reset overrides a same-cycle start mid-run
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    idle(17);
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    check("t6_outputs", int'({timerout, misses, running, done, overflow}), 0);
    idle(12);
    check("t6_stays_idle", int'({timerout, running}), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] l;
      target = 4'($urandom_range(0, 15));
      l = ($urandom_range(0, 3) == 0) ? 4'(m_tgt) : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 11) == 0), l);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
